int_latch_regs: RTL and testbench

//  Interrupt latch and readout block. It is the consumer of the interrupt control register (ICR) bits.
//  - Per-source interrupt events are edge-detected, gated by the ICR inhibit state and latched as pending.
//  - A single interrupt request (INTR) is raised to the computer while any pending bit is enabled.
//  - On a PIO read command, the pending word is snapshotted, cleared and shifted out serially, one bit per V1 cycle.

---
 rtl/int_latch_regs.sv | 118 +++++++++++
 tb/tb_int_latch_regs.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/int_latch_regs.sv
// Interrupt latch and readout: edge/level event capture gated by ICR inhibit, a
// pending word driving INTR, and a clear-on-read serial readout of the pending word.
module int_latch_regs #(
    parameter int NINT = 13,
    parameter bit EDGE = 1'b1
) (
    input  logic            SIM_CLK,
    input  logic            SIM_RST,
    input  logic            V1,
    input  logic [NINT-1:0] INT_SRC,
    input  logic [NINT-1:0] ICR_N,
    input  logic            RD_REQ,
    output logic            INTR,
    output logic [NINT-1:0] PEND,
    output logic            SER_DATA,
    output logic            SER_STRB,
    output logic            RD_DONE,
    output logic            RD_IGN
);

    localparam int CNT_W = (NINT > 1) ? $clog2(NINT) : 1;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t            state_q, state_d;
    logic [NINT-1:0]   pend_q, pend_d;
    logic [NINT-1:0]   snap_q, snap_d;
    logic [NINT-1:0]   src_q, src_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              intr_q, intr_d;
    logic              ser_data_q, ser_data_d;
    logic              ser_strb_q, ser_strb_d;
    logic              rd_done_q, rd_done_d;
    logic              rd_ign_q, rd_ign_d;
    logic [NINT-1:0]   arr;
    logic [NINT-1:0]   set;
    logic [NINT-1:0]   snap_sh;

    always_comb begin
        arr        = EDGE ? (INT_SRC & ~src_q) : INT_SRC;
        set        = arr & ICR_N;
        snap_sh    = snap_q >> 1;
        state_d    = state_q;
        pend_d     = pend_q | set;
        snap_d     = snap_q;
        cnt_d      = cnt_q;
        src_d      = INT_SRC;
        ser_data_d = 1'b0;
        ser_strb_d = 1'b0;
        rd_done_d  = 1'b0;
        rd_ign_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (RD_REQ) begin
                    // Clear-on-read, but an arrival in the read cycle itself is kept.
                    snap_d     = pend_q;
                    pend_d     = set;
                    cnt_d      = '0;
                    state_d    = SHIFT;
                    ser_strb_d = 1'b1;
                    ser_data_d = pend_q[0];
                end
            end
            SHIFT: begin
                rd_ign_d = RD_REQ;
                if (cnt_q == CNT_W'(NINT - 1)) begin
                    state_d   = DONE;
                    rd_done_d = 1'b1;
                end else begin
                    cnt_d      = cnt_q + 1'b1;
                    snap_d     = snap_sh;
                    ser_strb_d = 1'b1;
                    ser_data_d = snap_sh[0];
                end
            end
            DONE: begin
                rd_ign_d = RD_REQ;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
        intr_d = |(pend_d & ICR_N);
    end

    always_ff @(posedge SIM_CLK) begin
        if (SIM_RST) begin
            state_q    <= IDLE;
            pend_q     <= '0;
            snap_q     <= '0;
            cnt_q      <= '0;
            src_q      <= '1;
            intr_q     <= 1'b0;
            ser_data_q <= 1'b0;
            ser_strb_q <= 1'b0;
            rd_done_q  <= 1'b0;
            rd_ign_q   <= 1'b0;
        end else if (V1) begin
            state_q    <= state_d;
            pend_q     <= pend_d;
            snap_q     <= snap_d;
            cnt_q      <= cnt_d;
            src_q      <= src_d;
            intr_q     <= intr_d;
            ser_data_q <= ser_data_d;
            ser_strb_q <= ser_strb_d;
            rd_done_q  <= rd_done_d;
            rd_ign_q   <= rd_ign_d;
        end
    end

    assign INTR     = intr_q;
    assign PEND     = pend_q;
    assign SER_DATA = ser_data_q;
    assign SER_STRB = ser_strb_q;
    assign RD_DONE  = rd_done_q;
    assign RD_IGN   = rd_ign_q;

endmodule

// File: tb/tb_int_latch_regs.sv
// Bench for int_latch_regs: edge- and level-mode instances driven in parallel and
// compared against a word-level behavioural model plus fixed expected vectors.
module tb_int_latch_regs;

    localparam int NINT = 13;
    localparam logic [NINT-1:0] ALL = '1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic v1 = 1'b0;
    logic rd = 1'b0;
    logic [NINT-1:0] src = '0;
    logic [NINT-1:0] icr = '1;

    logic intr_e, data_e, strb_e, done_e, ign_e;
    logic intr_l, data_l, strb_l, done_l, ign_l;
    logic [NINT-1:0] pend_e, pend_l;

    int n_tests = 0;
    int n_fail  = 0;

    int_latch_regs #(.NINT(NINT), .EDGE(1'b1)) u_edge (
        .SIM_CLK(clk), .SIM_RST(rst), .V1(v1), .INT_SRC(src), .ICR_N(icr), .RD_REQ(rd),
        .INTR(intr_e), .PEND(pend_e), .SER_DATA(data_e), .SER_STRB(strb_e),
        .RD_DONE(done_e), .RD_IGN(ign_e));

    int_latch_regs #(.NINT(NINT), .EDGE(1'b0)) u_lvl (
        .SIM_CLK(clk), .SIM_RST(rst), .V1(v1), .INT_SRC(src), .ICR_N(icr), .RD_REQ(rd),
        .INTR(intr_l), .PEND(pend_l), .SER_DATA(data_l), .SER_STRB(strb_l),
        .RD_DONE(done_l), .RD_IGN(ign_l));

    initial forever #5 clk = ~clk;

    // Reference model, index 0 = edge mode, 1 = level mode. m_pos: -1 idle,
    // 0..NINT-1 bit being shown, NINT = done pulse.
    logic [NINT-1:0] m_pend[2], m_prev[2], m_snap[2];
    logic            m_intr[2], m_ign[2];
    int              m_pos[2];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_pend[d] = '0; m_prev[d] = ALL; m_snap[d] = '0;
            m_intr[d] = 1'b0; m_ign[d] = 1'b0; m_pos[d] = -1;
        end
    endtask

    task automatic model_step(input logic [NINT-1:0] s, input logic [NINT-1:0] ic, input logic r);
        for (int d = 0; d < 2; d++) begin
            logic [NINT-1:0] newbits;
            newbits = ((d == 0) ? (s & ~m_prev[d]) : s) & ic;
            m_ign[d] = 1'b0;
            if (m_pos[d] < 0) begin
                if (r) begin
                    m_snap[d] = m_pend[d];
                    m_pend[d] = newbits;
                    m_pos[d]  = 0;
                end else begin
                    m_pend[d] = m_pend[d] | newbits;
                end
            end else begin
                m_pend[d] = m_pend[d] | newbits;
                m_ign[d]  = r;
                m_pos[d]  = (m_pos[d] == NINT) ? -1 : m_pos[d] + 1;
            end
            m_intr[d] = |(m_pend[d] & ic);
            m_prev[d] = s;
        end
    endtask

    task automatic check_model(input string tag);
        for (int d = 0; d < 2; d++) begin
            logic [NINT-1:0] p;
            logic i, s, dn, ig, da, es;
            if (d == 0) begin p = pend_e; i = intr_e; s = strb_e; dn = done_e; ig = ign_e; da = data_e; end
            else        begin p = pend_l; i = intr_l; s = strb_l; dn = done_l; ig = ign_l; da = data_l; end
            es = (m_pos[d] >= 0) && (m_pos[d] < NINT);
            chk($sformatf("%s.m%0d.pend", tag, d), p, m_pend[d]);
            chk($sformatf("%s.m%0d.intr", tag, d), i, m_intr[d]);
            chk($sformatf("%s.m%0d.strb", tag, d), s, es);
            chk($sformatf("%s.m%0d.done", tag, d), dn, m_pos[d] == NINT);
            chk($sformatf("%s.m%0d.ign", tag, d), ig, m_ign[d]);
            if (es) chk($sformatf("%s.m%0d.data", tag, d), da, m_snap[d][m_pos[d]]);
        end
    endtask

    // One V1 cycle, then one non-V1 cycle with scrambled inputs that must change nothing.
    task automatic step(input logic [NINT-1:0] s, input logic [NINT-1:0] ic, input logic r);
        src = s; icr = ic; rd = r; v1 = 1'b1; rst = 1'b0;
        @(posedge clk); #1;
        model_step(s, ic, r);
        check_model("v1");
        v1 = 1'b0; src = NINT'($urandom); icr = NINT'($urandom); rd = 1'b1;
        @(posedge clk); #1;
        check_model("hold");
        rd = 1'b0;
    endtask

    task automatic do_reset(input logic [NINT-1:0] s);
        rst = 1'b1; v1 = 1'($urandom_range(0, 1)); src = s; icr = ALL; rd = 1'b0;
        @(posedge clk); #1;
        model_reset();
        check_model("rst");
        rst = 1'b0;
    endtask

    task automatic do_read(input logic [NINT-1:0] base, input logic [NINT-1:0] rd_src,
                           input int inj_cyc, input logic [NINT-1:0] inj_src, input int rd2_cyc,
                           output logic [NINT-1:0] w_e, output logic [NINT-1:0] w_l,
                           output int nbits, output int done_at, output bit ign_seen);
        w_e = '0; w_l = '0; nbits = 0; done_at = 0; ign_seen = 1'b0;
        step(base | rd_src, ALL, 1'b1);
        for (int k = 1; k <= 20; k++) begin
            if (strb_e) begin
                if (nbits < NINT) begin w_e[nbits] = data_e; w_l[nbits] = data_l; end
                nbits++;
            end
            if (done_e && done_at == 0) done_at = k;
            if (ign_e) ign_seen = 1'b1;
            if (k < 20) step(base | ((k == inj_cyc) ? inj_src : '0), ALL, k == rd2_cyc);
        end
    endtask

    typedef struct {
        logic [NINT-1:0] src;
        logic [NINT-1:0] icr;
        logic            rd;
        logic [NINT-1:0] pend;
        logic            intr;
    } vec_t;

    vec_t tbl[9];

    initial begin
        logic [NINT-1:0] we, wl;
        int nb, da;
        bit ig;
        int seen;

        tbl[0] = '{13'h0002, 13'h1FFF, 1'b0, 13'h0000, 1'b0};
        tbl[1] = '{13'h0000, 13'h1FEF, 1'b0, 13'h0000, 1'b0};
        tbl[2] = '{13'h0010, 13'h1FEF, 1'b0, 13'h0000, 1'b0};
        tbl[3] = '{13'h0000, 13'h1FFF, 1'b0, 13'h0000, 1'b0};
        tbl[4] = '{13'h0010, 13'h1FFF, 1'b0, 13'h0010, 1'b1};
        tbl[5] = '{13'h0010, 13'h1FFF, 1'b0, 13'h0010, 1'b1};
        tbl[6] = '{13'h0004, 13'h1FFF, 1'b0, 13'h0014, 1'b1};
        tbl[7] = '{13'h0000, 13'h1FEB, 1'b0, 13'h0014, 1'b0};
        tbl[8] = '{13'h0000, 13'h1FFF, 1'b0, 13'h0014, 1'b1};

        model_reset();
        @(posedge clk); #1;
        do_reset(13'h0002);
        chk("reset_pend", pend_e, 0);
        chk("reset_intr", intr_e, 0);
        chk("reset_strb", strb_e, 0);
        for (int i = 0; i < 9; i++) begin
            step(tbl[i].src, tbl[i].icr, tbl[i].rd);
            chk($sformatf("tbl%0d.pend", i), pend_e, tbl[i].pend);
            chk($sformatf("tbl%0d.intr", i), intr_e, tbl[i].intr);
        end

        // Full readout of 0x1005
        do_reset('0);
        step('0, ALL, 1'b0);
        step(13'h1005, ALL, 1'b0);
        step('0, ALL, 1'b0);
        chk("pre_read_pend", pend_e, 13'h1005);
        do_read('0, '0, -1, '0, -1, we, wl, nb, da, ig);
        chk("read1_word", we, 13'h1005);
        chk("read1_bits", nb, NINT);
        chk("read1_done_cyc", da, 14);
        chk("read1_pend", pend_e, 0);
        chk("read1_intr", intr_e, 0);

        // Arrival in the read cycle goes to the next word
        step(13'h0001, ALL, 1'b0);
        step('0, ALL, 1'b0);
        do_read('0, 13'h0080, -1, '0, -1, we, wl, nb, da, ig);
        chk("read2_word", we, 13'h0001);
        chk("read2_pend", pend_e, 13'h0080);

        // Ignored RD_REQ mid-shift and a mid-shift arrival
        do_read('0, '0, 6, 13'h0008, 4, we, wl, nb, da, ig);
        chk("read3_word", we, 13'h0080);
        chk("read3_ign", ig, 1);
        chk("read3_done_cyc", da, 14);
        chk("read3_pend", pend_e, 13'h0008);
        do_read('0, '0, -1, '0, -1, we, wl, nb, da, ig);
        chk("read4_word", we, 13'h0008);
        chk("read4_pend", pend_e, 0);

        // Reset aborts a readout at bit 6
        do_reset('0);
        step('0, ALL, 1'b0);
        step(ALL, ALL, 1'b0);
        step('0, ALL, 1'b0);
        step('0, ALL, 1'b1);
        for (int k = 0; k < 6; k++) step('0, ALL, 1'b0);
        chk("abort_strb_before", strb_e, 1);
        chk("abort_bit6", data_e, 1);
        do_reset('0);
        chk("abort_strb", strb_e, 0);
        chk("abort_done", done_e, 0);
        chk("abort_pend", pend_e, 0);
        seen = 0;
        for (int k = 0; k < 16; k++) begin
            step('0, ALL, 1'b0);
            if (done_e || strb_e) seen++;
        end
        chk("abort_quiet", seen, 0);

        // Level mode re-latches a held source after the read
        do_reset('0);
        step('0, ALL, 1'b0);
        step(13'h0020, ALL, 1'b0);
        chk("lvl_pend", pend_l, 13'h0020);
        do_read(13'h0020, '0, -1, '0, -1, we, wl, nb, da, ig);
        chk("lvl_word", wl, 13'h0020);
        chk("edge_word", we, 13'h0020);
        chk("lvl_relatch", pend_l, 13'h0020);
        chk("edge_cleared", pend_e, 0);
        step('0, ALL, 1'b0);

        // Randomised traffic against the model
        do_reset('0);
        for (int i = 0; i < 700; i++) begin
            logic [NINT-1:0] s, ic;
            if ($urandom_range(0, 63) == 0) do_reset(NINT'($urandom));
            s  = NINT'($urandom) & NINT'($urandom) & NINT'($urandom);
            ic = ($urandom_range(0, 3) == 0) ? NINT'($urandom) : ALL;
            step(s, ic, $urandom_range(0, 11) == 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
